// File: rtl/morra_match_controller.sv
// Match sequencer for the MorraCinese game core: collects both players' moves,
// drives START/move pairs into the core and tallies game results into a match winner.
module morra_match_controller #(
  parameter int unsigned N_GAMES = 3,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned SW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          match_start,
  input  logic [1:0]    p1_move,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [1:0]    p2_move,
  input  logic          p2_valid,
  output logic          p2_ready,
  output logic [1:0]    core_p1,
  output logic [1:0]    core_p2,
  output logic          core_start,
  input  logic [1:0]    core_round,
  input  logic [1:0]    core_game,
  output logic [SW-1:0] score1,
  output logic [SW-1:0] score2,
  output logic [SW-1:0] games_played,
  output logic          busy,
  output logic          match_done,
  output logic [1:0]    match_winner
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] WIN   = SW'((N_GAMES + 1) / 2);
  localparam logic [SW-1:0] NG    = SW'(N_GAMES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_NEWGAME = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          full1_q, full1_d, full2_q, full2_d;
  logic [1:0]    mv1_q, mv1_d, mv2_q, mv2_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] score1_q, score1_d, score2_q, score2_d, games_q, games_d;
  logic [1:0]    winner_q, winner_d;

  // The round result only matters through the game outcome.
  logic unused_round;
  assign unused_round = ^core_round;

  always_comb begin
    state_d  = state_q;
    full1_d  = full1_q;
    full2_d  = full2_q;
    mv1_d    = mv1_q;
    mv2_d    = mv2_q;
    tcnt_d   = tcnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    games_d  = games_q;
    winner_d = winner_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (match_start) begin
          state_d  = ST_NEWGAME;
          score1_d = '0;
          score2_d = '0;
          games_d  = '0;
          winner_d = 2'b00;
        end
      end
      ST_NEWGAME: begin
        state_d = ST_COLLECT;
        tcnt_d  = '0;
        full1_d = 1'b0;
        full2_d = 1'b0;
        mv1_d   = 2'b00;
        mv2_d   = 2'b00;
      end
      ST_COLLECT: begin
        // Illegal 00 moves are handshaken away without filling the slot.
        if (p1_valid && !full1_q && (p1_move != 2'b00)) begin
          full1_d = 1'b1;
          mv1_d   = p1_move;
        end
        if (p2_valid && !full2_q && (p2_move != 2'b00)) begin
          full2_d = 1'b1;
          mv2_d   = p2_move;
        end
        tcnt_d = tcnt_q + 1'b1;
        if (full1_d && full2_d) begin
          state_d = ST_ISSUE;
        end else if (tcnt_q == TLAST) begin
          state_d  = ST_DONE;
          winner_d = {full2_d, full1_d};
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESULT;
        full1_d = 1'b0;
        full2_d = 1'b0;
        mv1_d   = 2'b00;
        mv2_d   = 2'b00;
      end
      ST_RESULT: begin
        if (core_game == 2'b00) begin
          state_d = ST_COLLECT;
          tcnt_d  = '0;
        end else begin
          if ((core_game == 2'b01) && (score1_q != '1)) score1_d = score1_q + 1'b1;
          if ((core_game == 2'b10) && (score2_q != '1)) score2_d = score2_q + 1'b1;
          if (games_q != '1) games_d = games_q + 1'b1;
          if ((score1_d >= WIN) || (score2_d >= WIN) || (games_d >= NG)) begin
            state_d = ST_DONE;
            if (score1_d > score2_d)      winner_d = 2'b01;
            else if (score2_d > score1_d) winner_d = 2'b10;
            else                          winner_d = 2'b11;
          end else begin
            state_d = ST_NEWGAME;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      full1_q  <= 1'b0;
      full2_q  <= 1'b0;
      mv1_q    <= 2'b00;
      mv2_q    <= 2'b00;
      tcnt_q   <= '0;
      score1_q <= '0;
      score2_q <= '0;
      games_q  <= '0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      full1_q  <= full1_d;
      full2_q  <= full2_d;
      mv1_q    <= mv1_d;
      mv2_q    <= mv2_d;
      tcnt_q   <= tcnt_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      games_q  <= games_d;
      winner_q <= winner_d;
    end
  end

  assign p1_ready     = (state_q == ST_COLLECT) && !full1_q;
  assign p2_ready     = (state_q == ST_COLLECT) && !full2_q;
  assign core_p1      = (state_q == ST_ISSUE) ? mv1_q : 2'b00;
  assign core_p2      = (state_q == ST_ISSUE) ? mv2_q : 2'b00;
  assign core_start   = (state_q == ST_NEWGAME);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign match_done   = (state_q == ST_DONE);
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign games_played = games_q;
  assign match_winner = winner_q;

endmodule
